// File: rtl/store_size_merge_if.sv
// Store request / memory-side bundle for the sub-word store merge engine.
// The master drives the request and the memory read data; the slave is the engine.
interface store_size_merge_if;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic [31:0] mem_rd_data;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] merged_data;
  logic        busy;
  logic        done;
  logic        misaligned;

  modport master (
    output start, size, addr, store_data, mem_rd_data,
    input  mem_addr, mem_wr, merged_data, busy, done, misaligned
  );

  modport slave (
    input  start, size, addr, store_data, mem_rd_data,
    output mem_addr, mem_wr, merged_data, busy, done, misaligned
  );
endinterface

// File: rtl/store_size_merge.sv
// Byte/halfword read-modify-write store engine; word stores skip the read.
// Word: write cycle 1, done cycle 2. Sub-word: read L cycles, write L+1, done L+2.
module store_size_merge #(
  parameter int MEM_READ_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  store_size_merge_if.slave bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        is_byte_q;
  logic [1:0]  lane_q;
  logic [15:0] data_q;

  // Little-endian lanes: lane 0 is bits 7:0; halfwords use lane[1] only.
  function automatic logic [31:0] merge(input logic [31:0] mem, input logic [15:0] sd,
                                        input logic [1:0] lane, input logic is_byte);
    logic [31:0] r;
    r = mem;
    if (is_byte) begin
      case (lane)
        2'd0: r[7:0]   = sd[7:0];
        2'd1: r[15:8]  = sd[7:0];
        2'd2: r[23:16] = sd[7:0];
        default: r[31:24] = sd[7:0];
      endcase
    end else if (lane[1]) begin
      r[31:16] = sd;
    end else begin
      r[15:0] = sd;
    end
    return r;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= 3'd0;
      is_byte_q       <= 1'b0;
      lane_q          <= 2'd0;
      data_q          <= 16'd0;
      bus.mem_addr    <= 32'd0;
      bus.merged_data <= 32'd0;
      bus.mem_wr      <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.misaligned  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            bus.mem_addr <= {bus.addr[31:2], 2'b00};
            is_byte_q    <= (bus.size == 2'b10);
            lane_q       <= bus.addr[1:0];
            data_q       <= bus.store_data[15:0];
            bus.busy     <= 1'b1;
            if (bus.size == 2'b00) begin
              bus.merged_data <= bus.store_data;
              bus.mem_wr      <= 1'b1;
              state           <= WRITE;
            end else if (bus.size == 2'b11 || (bus.size == 2'b01 && bus.addr[0])) begin
              bus.done       <= 1'b1;
              bus.misaligned <= 1'b1;
              state          <= DONE;
            end else begin
              cnt   <= 3'(MEM_READ_LATENCY);
              state <= READ;
            end
          end
        end
        READ: begin
          // Memory data is valid in the last counted cycle; capture it at that edge.
          if (cnt == 3'd1) begin
            bus.merged_data <= merge(bus.mem_rd_data, data_q, lane_q, is_byte_q);
            bus.mem_wr      <= 1'b1;
            state           <= WRITE;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WRITE: begin
          bus.mem_wr <= 1'b0;
          bus.done   <= 1'b1;
          state      <= DONE;
        end
        default: begin
          bus.done       <= 1'b0;
          bus.misaligned <= 1'b0;
          bus.busy       <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_size_merge.sv
// Scoreboard bench: three engines (read latency 1, 3, 4) share one request stream.
module tb_store_size_merge;

  typedef struct {
    logic [31:0] data;
    logic [31:0] addr;
    int          s0;
    bit          word;
    bit          rej;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] store_data;
  int          cyc = 0;
  int          rd_base = -100;
  logic [31:0] rd_val = 32'd0;
  int          nvec = 0;
  int          nfail = 0;
  exp_t        wr_q[3][$];
  exp_t        done_q[3][$];
  logic [67:0] outs[3];

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int L = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    store_size_merge_if bus ();
    store_size_merge #(.MEM_READ_LATENCY(L)) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
    );
    assign bus.start       = start;
    assign bus.size        = size;
    assign bus.addr        = addr;
    assign bus.store_data  = store_data;
    // Memory data is only valid in the read cycle the latency implies.
    assign bus.mem_rd_data = (cyc == rd_base + L - 1) ? rd_val : 32'hA5A5_A5A5;
    assign outs[g] = {bus.mem_addr, bus.merged_data, bus.mem_wr, bus.busy,
                      bus.done, bus.misaligned};

    exp_t ew, ed;
    always @(negedge clock) begin
      if (bus.mem_wr === 1'b1 && bus.done === 1'b1) begin
        nvec++; nfail++;
        $display("FAIL overlap%0d mem_wr=1 done=1 required not both high at cyc %0d", g, cyc);
      end
      if (bus.mem_wr === 1'b1) begin
        nvec++;
        if (wr_q[g].size() == 0) begin
          nfail++;
          $display("FAIL wr%0d unexpected write data=%h addr=%h cyc=%0d required no write",
                   g, bus.merged_data, bus.mem_addr, cyc);
        end else begin
          ew = wr_q[g].pop_front();
          if (bus.merged_data !== ew.data || bus.mem_addr !== ew.addr || bus.busy !== 1'b1 ||
              cyc != (ew.word ? ew.s0 : ew.s0 + L)) begin
            nfail++;
            $display("FAIL wr%0d data=%h addr=%h busy=%b cyc=%0d required data=%h addr=%h busy=1 cyc=%0d",
                     g, bus.merged_data, bus.mem_addr, bus.busy, cyc, ew.data, ew.addr,
                     ew.word ? ew.s0 : ew.s0 + L);
          end
        end
      end
      if (bus.done === 1'b1) begin
        nvec++;
        if (done_q[g].size() == 0) begin
          nfail++;
          $display("FAIL done%0d unexpected done at cyc=%0d required none", g, cyc);
        end else begin
          ed = done_q[g].pop_front();
          if (bus.misaligned !== ed.rej || bus.busy !== 1'b1 ||
              cyc != (ed.rej ? ed.s0 : ed.word ? ed.s0 + 1 : ed.s0 + L + 1)) begin
            nfail++;
            $display("FAIL done%0d misaligned=%b busy=%b cyc=%0d required misaligned=%b busy=1 cyc=%0d",
                     g, bus.misaligned, bus.busy, cyc, ed.rej,
                     ed.rej ? ed.s0 : ed.word ? ed.s0 + 1 : ed.s0 + L + 1);
          end
        end
      end
    end
  end

  function automatic int pending();
    int n = 0;
    for (int k = 0; k < 3; k++) n += wr_q[k].size() + done_q[k].size();
    return n;
  endfunction

  task automatic check_zero(input string name);
    for (int k = 0; k < 3; k++) begin
      nvec++;
      if (outs[k] !== 68'd0) begin
        nfail++;
        $display("FAIL %s%0d outputs=%h required all zero", name, k, outs[k]);
      end
    end
  endtask

  // pulse[k] drives start during cycle k after acceptance (requests there must be ignored).
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] m, input logic [31:0] exp_data, input bit rej,
                          input logic [7:0] pulse);
    exp_t e;
    int   k;
    @(negedge clock);
    start = 1'b1; size = sz; addr = a; store_data = d;
    rd_base = cyc + 1; rd_val = m;
    e.data = exp_data; e.addr = {a[31:2], 2'b00}; e.s0 = cyc + 1;
    e.word = (sz == 2'b00); e.rej = rej;
    for (int q = 0; q < 3; q++) begin
      if (!rej) wr_q[q].push_back(e);
      done_q[q].push_back(e);
    end
    k = 0;
    while (pending() != 0 && k < 20) begin
      @(negedge clock);
      k++;
      start = (k < 8) ? pulse[k] : 1'b0;
      size = 2'b00; addr = 32'h0000_0999; store_data = 32'h0BAD_0BAD;
    end
    start = 1'b0;
    if (pending() != 0) begin
      nvec++; nfail++;
      $display("FAIL timeout addr=%h pending=%0d required 0", a, pending());
      for (int q = 0; q < 3; q++) begin
        wr_q[q].delete();
        done_q[q].delete();
      end
    end
    repeat (2) @(negedge clock);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1; start = 1'b0; size = 2'b00; addr = 32'd0; store_data = 32'd0;
    repeat (3) @(negedge clock);
    check_zero("reset");
    reset = 1'b0;

    do_store(2'b10, 32'h0000_0102, 32'h0000_00AB, 32'h1122_3344, 32'h11AB_3344, 1'b0, 8'h00);
    do_store(2'b01, 32'h0000_0006, 32'hFFFF_BEEF, 32'h1122_3344, 32'hBEEF_3344, 1'b0, 8'h00);
    do_store(2'b00, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_0000, 32'hDEAD_BEEF, 1'b0, 8'h00);
    do_store(2'b01, 32'h0000_0003, 32'h0000_1234, 32'h1122_3344, 32'h0000_0000, 1'b1, 8'h00);
    do_store(2'b11, 32'h0000_0020, 32'h0000_1234, 32'h1122_3344, 32'h0000_0000, 1'b1, 8'h00);
    do_store(2'b10, 32'h0000_0203, 32'h0000_005A, 32'h1122_3344, 32'h5A22_3344, 1'b0, 8'h00);
    do_store(2'b10, 32'h0000_0200, 32'h1234_56C3, 32'hAABB_CCDD, 32'hAABB_CCC3, 1'b0, 8'h00);
    do_store(2'b01, 32'h0000_0300, 32'h1234_CAFE, 32'hAABB_CCDD, 32'hAABB_CAFE, 1'b0, 8'h00);
    do_store(2'b10, 32'h0000_0101, 32'h0000_0077, 32'h1122_3344, 32'h1122_7744, 1'b0, 8'h00);

    // Reset during cycle 2: only the latency-1 engine has already written by then.
    @(negedge clock);
    start = 1'b1; size = 2'b10; addr = 32'h0000_0040; store_data = 32'h0000_0099;
    rd_base = cyc + 1; rd_val = 32'h0000_0000;
    e.data = 32'h0000_0099; e.addr = 32'h0000_0040; e.s0 = cyc + 1; e.word = 1'b0; e.rej = 1'b0;
    wr_q[0].push_back(e);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check_zero("rst_mid");
    reset = 1'b0;
    nvec++;
    if (pending() != 0) begin
      nfail++;
      $display("FAIL rst_pending pending=%0d required 0", pending());
      for (int q = 0; q < 3; q++) begin
        wr_q[q].delete();
        done_q[q].delete();
      end
    end
    do_store(2'b10, 32'h0000_0041, 32'h0000_0066, 32'hFFFF_FFFF, 32'hFFFF_66FF, 1'b0, 8'h00);

    // start pulsed while the engines are in READ/WRITE/DONE must not spawn a second store.
    do_store(2'b10, 32'h0000_0050, 32'h0000_0001, 32'h1020_3040, 32'h1020_3001, 1'b0, 8'h06);
    do_store(2'b00, 32'h0000_0060, 32'hCAFE_F00D, 32'h0000_0000, 32'hCAFE_F00D, 1'b0, 8'h06);

    repeat (8) @(negedge clock);
    nvec++;
    if (pending() != 0) begin
      nfail++;
      $display("FAIL drain pending=%0d required 0", pending());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
